tick_gen: RTL and testbench

- Programmable clock-enable generator. Sits directly upstream of the synchronous counter and drives its CE input.
- Emits single-cycle CE pulses every DIV+1 clock cycles. Runs either continuously or as a burst of NPULSE pulses, and flags burst completion.
- Provides start/stop/pause control so counter advance rate is set by software-visible registers rather than by raw CLK.

---
 rtl/tick_gen.sv | 118 +++++++++++
 tb/tb_tick_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// tick_gen: programmable clock-enable generator, continuous or burst.
// Optional EXT_TRIG start input enabled by defining TICK_GEN_EXTTRIG_EN.
`timescale 1ns/1ps
module tick_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 8,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic                 LOAD,
  input  logic [CNT_WIDTH-1:0] NPULSE,
  input  logic                 MODE,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 PAUSE,
`ifdef TICK_GEN_EXTTRIG_EN
  input  logic                 EXT_TRIG,
`endif
  output logic                 CE,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] pc;
  logic [CNT_WIDTH-1:0] left;
  logic                 mode_r;
  logic [DIV_WIDTH-1:0] rv;
  logic                 start_i;

  // A coincident LOAD wins over the stored divisor for this reload.
  assign rv = LOAD ? DIV : div_r;

`ifdef TICK_GEN_EXTTRIG_EN
  logic s1, s2, s3;

  // Two-flop synchroniser plus a history flop for rising-edge detect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= EXT_TRIG;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_i = START | (s2 & ~s3);
`else
  assign start_i = START;
`endif

  assign BUSY = (state == RUN);

  // Prescaler, burst counter and registered CE/DONE pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      CE     <= 1'b0;
      DONE   <= 1'b0;
      div_r  <= DEFAULT_DIV;
      pc     <= '0;
      left   <= '0;
      mode_r <= 1'b0;
    end else begin
      CE   <= 1'b0;
      DONE <= 1'b0;
      if (LOAD)
        div_r <= DIV;
      case (state)
        IDLE: begin
          if (start_i && !STOP) begin
            if (!MODE) begin
              pc     <= rv;
              mode_r <= 1'b0;
              state  <= RUN;
            end else if (NPULSE != '0) begin
              pc     <= rv;
              left   <= NPULSE;
              mode_r <= 1'b1;
              state  <= RUN;
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        RUN: begin
          if (STOP) begin
            state <= IDLE;
          end else if (PAUSE) begin
            pc <= pc;
          end else if (pc != '0) begin
            pc <= pc - 1'b1;
          end else begin
            CE <= 1'b1;
            pc <= rv;
            if (mode_r) begin
              left <= left - 1'b1;
              if (left == CNT_WIDTH'(1)) begin
                DONE  <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed self-checking bench for tick_gen.
// Covers reset, continuous, burst, pause/reload, priority and EXT_TRIG.
`timescale 1ns/1ps
module tb_tick_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIV;
  logic       LOAD;
  logic [7:0] NPULSE;
  logic       MODE;
  logic       START;
  logic       STOP;
  logic       PAUSE;
`ifdef TICK_GEN_EXTTRIG_EN
  logic       EXT_TRIG;
`endif
  logic       CE;
  logic       BUSY;
  logic       DONE;

  int passed = 0;
  int total  = 0;

  tick_gen #(.DIV_WIDTH(8), .CNT_WIDTH(8), .DEFAULT_DIV(8'd0)) dut (
    .CLK(CLK),
    .RST(RST),
    .DIV(DIV),
    .LOAD(LOAD),
    .NPULSE(NPULSE),
    .MODE(MODE),
    .START(START),
    .STOP(STOP),
    .PAUSE(PAUSE),
`ifdef TICK_GEN_EXTTRIG_EN
    .EXT_TRIG(EXT_TRIG),
`endif
    .CE(CE),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    LOAD   = 1'b0;
    START  = 1'b0;
    STOP   = 1'b0;
    PAUSE  = 1'b0;
    MODE   = 1'b0;
    NPULSE = 8'd0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DIV = 8'd0;
    clr();
`ifdef TICK_GEN_EXTTRIG_EN
    EXT_TRIG = 1'b0;
`endif
    #1;
    total++;
    if ({CE, DONE, BUSY} !== 3'b000)
      $display("FAIL reset_init got=%b want=000", {CE, DONE, BUSY});
    else passed++;
    cyc();
    total++;
    if ({CE, DONE, BUSY} !== 3'b000)
      $display("FAIL reset_hold got=%b want=000", {CE, DONE, BUSY});
    else passed++;
    RST = 1'b0;
    LOAD = 1'b1; DIV = 8'd2;
    START = 1'b1; MODE = 1'b1; NPULSE = 8'd3;
    cyc();
    clr();
    total++;
    if (BUSY !== 1'b1)
      $display("FAIL reset_burst_busy got=%b want=1", BUSY);
    else passed++;
    repeat (3) cyc();
    total++;
    if (CE !== 1'b1)
      $display("FAIL reset_burst_ce got=%b want=1", CE);
    else passed++;
    #2 RST = 1'b1;
    #1;
    total++;
    if ({CE, DONE, BUSY} !== 3'b000)
      $display("FAIL reset_async got=%b want=000", {CE, DONE, BUSY});
    else passed++;
    cyc();
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total++;
      if ({CE, BUSY} !== 2'b00)
        $display("FAIL reset_idle k=%0d got=%b want=00", k, {CE, BUSY});
      else passed++;
    end
  endtask

  task automatic test_continuous();
    logic exp;
    LOAD = 1'b1; DIV = 8'd3;
    cyc();
    clr();
    START = 1'b1;
    cyc();
    clr();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp = (k % 4 == 0);
      total++;
      if ({CE, BUSY} !== {exp, 1'b1})
        $display("FAIL cont k=%0d got=%b want=%b", k, {CE, BUSY}, {exp, 1'b1});
      else passed++;
    end
    STOP = 1'b1;
    cyc();
    clr();
    total++;
    if ({CE, BUSY} !== 2'b00)
      $display("FAIL cont_stop got=%b want=00", {CE, BUSY});
    else passed++;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      total++;
      if (CE !== 1'b0)
        $display("FAIL cont_after_stop k=%0d got=%b want=0", k, CE);
      else passed++;
    end
  endtask

  task automatic test_burst();
    logic ce_e, dn_e, bz_e;
    LOAD = 1'b1; DIV = 8'd1;
    cyc();
    clr();
    START = 1'b1; MODE = 1'b1; NPULSE = 8'd3;
    cyc();
    clr();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      ce_e = (k == 2 || k == 4 || k == 6);
      dn_e = (k == 6);
      bz_e = (k < 6);
      total++;
      if ({CE, DONE, BUSY} !== {ce_e, dn_e, bz_e})
        $display("FAIL burst k=%0d got=%b want=%b", k,
                 {CE, DONE, BUSY}, {ce_e, dn_e, bz_e});
      else passed++;
    end
    START = 1'b1; MODE = 1'b1; NPULSE = 8'd0;
    cyc();
    clr();
    total++;
    if ({CE, DONE, BUSY} !== 3'b010)
      $display("FAIL burst_zero got=%b want=010", {CE, DONE, BUSY});
    else passed++;
    cyc();
    total++;
    if ({CE, DONE, BUSY} !== 3'b000)
      $display("FAIL burst_zero_after got=%b want=000", {CE, DONE, BUSY});
    else passed++;
  endtask

  task automatic test_pause_reload();
    logic exp;
    LOAD = 1'b1; DIV = 8'd4;
    cyc();
    clr();
    START = 1'b1;
    cyc();
    clr();
    for (int k = 1; k <= 30; k++) begin
      clr();
      PAUSE = (k >= 6 && k <= 10);
      if (k == 16) begin LOAD = 1'b1; DIV = 8'd1; end
      if (k == 26) begin LOAD = 1'b1; DIV = 8'd3; end
      cyc();
      exp = (k == 5 || k == 15 || k == 20 || k == 22 ||
             k == 24 || k == 26 || k == 30);
      total++;
      if (CE !== exp)
        $display("FAIL pause_reload k=%0d got=%b want=%b", k, CE, exp);
      else passed++;
    end
    clr();
    STOP = 1'b1;
    cyc();
    clr();
  endtask

  task automatic test_priority();
    logic exp;
    int   cnt;
    int   tcs;
    LOAD = 1'b1; DIV = 8'd4; START = 1'b1;
    cyc();
    clr();
    repeat (2) cyc();
    STOP = 1'b1; PAUSE = 1'b1;
    cyc();
    clr();
    total++;
    if ({CE, BUSY} !== 2'b00)
      $display("FAIL prio_stop_pause got=%b want=00", {CE, BUSY});
    else passed++;
    LOAD = 1'b1; DIV = 8'd3; START = 1'b1;
    cyc();
    clr();
    for (int k = 1; k <= 6; k++) begin
      START = (k == 2);
      cyc();
      START = 1'b0;
      exp = (k == 4);
      total++;
      if ({CE, BUSY} !== {exp, 1'b1})
        $display("FAIL prio_restart k=%0d got=%b want=%b", k,
                 {CE, BUSY}, {exp, 1'b1});
      else passed++;
    end
    STOP = 1'b1;
    cyc();
    clr();
    LOAD = 1'b1; DIV = 8'd0; START = 1'b1;
    cyc();
    clr();
    cnt = 0;
    tcs = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      total++;
      if (CE !== 1'b1)
        $display("FAIL div0_ce k=%0d got=%b want=1", k, CE);
      else passed++;
      if (CE === 1'b1) begin
        if (cnt == 7) tcs++;
        cnt = (cnt + 1) % 8;
      end
    end
    total++;
    if (tcs != 2)
      $display("FAIL div0_tc got=%0d want=2", tcs);
    else passed++;
    STOP = 1'b1;
    cyc();
    clr();
  endtask

`ifdef TICK_GEN_EXTTRIG_EN
  task automatic test_ext_trig();
    logic exp;
    LOAD = 1'b1; DIV = 8'd3;
    cyc();
    clr();
    EXT_TRIG = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      exp = (k == 3);
      total++;
      if (BUSY !== exp)
        $display("FAIL ext_trig k=%0d got=%b want=%b", k, BUSY, exp);
      else passed++;
    end
    STOP = 1'b1;
    cyc();
    clr();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      total++;
      if (BUSY !== 1'b0)
        $display("FAIL ext_trig_held k=%0d got=%b want=0", k, BUSY);
      else passed++;
    end
    EXT_TRIG = 1'b0;
    repeat (3) cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_pause_reload();
    test_priority();
`ifdef TICK_GEN_EXTTRIG_EN
    test_ext_trig();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
